// File: rtl/alu16_pkg.sv
// Shared definitions for the 16-bit bit-serial ALU: widths, opcode encoding, request struct.
package alu16_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_NOTA  = 3'b101;
  localparam logic [2:0] OP_PASSA = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
  } req_t;

  // Bit 16 of the result: carry for ADD, borrow (inverted carry) for SUB, 0 otherwise.
  function automatic logic final_msb(input logic [2:0] op, input logic cy);
    case (op)
      OP_ADD:  final_msb = cy;
      OP_SUB:  final_msb = ~cy;
      default: final_msb = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu16_bit_slice.sv
// One-bit ALU slice: full adder (with B inverted for SUB) plus the bitwise ops.
module alu16_bit_slice
  import alu16_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] op,
  output logic       r,
  output logic       cout
);

  logic bx;
  assign bx = (op == OP_SUB) ? ~b : b;

  always_comb begin
    r    = 1'b0;
    cout = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        r    = a ^ bx ^ cin;
        cout = (a & bx) | (cin & (a ^ bx));
      end
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NOTA:  r = ~a;
      OP_PASSA: r = a;
      default:  r = b;
    endcase
  end

endmodule

// File: rtl/alu16_bit_serial.sv
// 16-bit bit-serial ALU, one result bit per clock LSB first.
// Define ALU16_BUSY_PORT_EN to expose the internal busy flag as an output.
module alu16_bit_serial
  import alu16_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic [2:0]       op,
  output logic [WIDTH:0]   out,
  output logic [CNT_W-1:0] count
`ifdef ALU16_BUSY_PORT_EN
  ,
  output logic             busy
`endif
);

  req_t             req_q;
  logic [WIDTH-1:0] data_q;
  logic             msb_q;
  logic             carry_q;
  logic             busy_q;
  logic             r;
  logic             cout;

  alu16_bit_slice u_slice (
    .a    (req_q.a[count]),
    .b    (req_q.b[count]),
    .cin  (carry_q),
    .op   (req_q.op),
    .r    (r),
    .cout (cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= '0;
      data_q  <= '0;
      msb_q   <= 1'b0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      count   <= '0;
    end else if (on) begin
      // SUB is A + ~B + 1: the +1 enters as the initial carry.
      req_q   <= '{a: ina, b: inb, op: op};
      data_q  <= '0;
      msb_q   <= 1'b0;
      carry_q <= (op == OP_SUB);
      busy_q  <= 1'b1;
      count   <= '0;
    end else if (busy_q) begin
      data_q[count] <= r;
      carry_q       <= cout;
      count         <= CNT_W'(count + 1'b1);
      if (count == CNT_W'(WIDTH - 1)) begin
        busy_q <= 1'b0;
        msb_q  <= final_msb(req_q.op, cout);
      end
    end
  end

  assign out = {msb_q, data_q};

`ifdef ALU16_BUSY_PORT_EN
  assign busy = busy_q;
`endif

endmodule

// File: tb/tb_alu16_bit_serial.sv
// Self-checking bench for alu16_bit_serial: directed vectors plus randomized ops vs an arithmetic model.
module tb_alu16_bit_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        on  = 1'b0;
  logic [15:0] ina = '0;
  logic [15:0] inb = '0;
  logic [2:0]  op  = '0;
  logic [16:0] out;
  logic [3:0]  count;

  int passed = 0;
  int total  = 0;

  alu16_bit_serial dut (
    .clk   (clk),
    .rst   (rst),
    .on    (on),
    .ina   (ina),
    .inb   (inb),
    .op    (op),
    .out   (out),
    .count (count)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] o);
    logic [16:0] t;
    case (o)
      3'd0: model = {1'b0, a} + {1'b0, b};
      3'd1: begin
        t = {1'b0, a} + {1'b0, ~b} + 17'd1;
        model = {~t[16], t[15:0]};
      end
      3'd2: model = {1'b0, a & b};
      3'd3: model = {1'b0, a | b};
      3'd4: model = {1'b0, a ^ b};
      3'd5: model = {1'b0, ~a};
      3'd6: model = {1'b0, a};
      default: model = {1'b0, b};
    endcase
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] b, input logic [2:0] o, input int hold);
    ina = a; inb = b; op = o; on = 1'b1;
    tick(hold);
    on = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    total++;
    if (out !== 17'h0 || count !== 4'd0)
      $display("FAIL reset: out=%h count=%0d want out=0 count=0", out, count);
    else passed++;
    tick(3);
    total++;
    if (out !== 17'h0 || count !== 4'd0)
      $display("FAIL reset_idle: out=%h count=%0d want out=0 count=0", out, count);
    else passed++;
  endtask

  task automatic test_add_partial();
    load(16'h7003, 16'hC003, 3'd0, 1);
    tick(4);
    total++;
    if (out !== 17'h00006 || count !== 4'd4)
      $display("FAIL add_partial: out=%h count=%0d want 00006/4", out, count);
    else passed++;
    tick(12);
    total++;
    if (out !== 17'h13006 || count !== 4'd0)
      $display("FAIL add_final: out=%h count=%0d want 13006/0", out, count);
    else passed++;
  endtask

  task automatic test_directed_ops();
    logic [15:0] va [8] = '{16'h7003, 16'hC003, 16'h7003, 16'h7003, 16'h7003, 16'h7003, 16'h7003, 16'h7003};
    logic [15:0] vb [8] = '{16'hC003, 16'h7003, 16'hC003, 16'hC003, 16'hC003, 16'hC003, 16'hC003, 16'hC003};
    logic [2:0]  vo [8] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [16:0] ve [8] = '{17'h1B000, 17'h05000, 17'h04003, 17'h0F003, 17'h0B000, 17'h08FFC, 17'h07003, 17'h0C003};
    for (int i = 0; i < 8; i++) begin
      load(va[i], vb[i], vo[i], 1);
      tick(16);
      total++;
      if (out !== ve[i] || count !== 4'd0)
        $display("FAIL op%0d: out=%h count=%0d want %h/0", vo[i], out, count, ve[i]);
      else passed++;
      tick(2);
      total++;
      if (out !== ve[i] || count !== 4'd0)
        $display("FAIL op%0d_hold: out=%h count=%0d want %h/0", vo[i], out, count, ve[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    load(16'h7003, 16'hC003, 3'd0, 1);
    tick(7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (out !== 17'h0 || count !== 4'd0)
      $display("FAIL reset_mid: out=%h count=%0d want 0/0", out, count);
    else passed++;
    tick(20);
    total++;
    if (out !== 17'h0 || count !== 4'd0)
      $display("FAIL reset_mid_idle: out=%h count=%0d want 0/0", out, count);
    else passed++;
  endtask

  task automatic test_restart();
    load(16'h1234, 16'h5678, 3'd0, 1);
    tick(9);
    load(16'hFFFF, 16'h0001, 3'd0, 1);
    total++;
    if (out !== 17'h0 || count !== 4'd0)
      $display("FAIL restart_load: out=%h count=%0d want 0/0", out, count);
    else passed++;
    tick(16);
    total++;
    if (out !== 17'h10000 || count !== 4'd0)
      $display("FAIL restart_final: out=%h count=%0d want 10000/0", out, count);
    else passed++;
  endtask

  task automatic test_on_held();
    ina = 16'h7003; inb = 16'hC003; op = 3'd0; on = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (count !== 4'd0 || out !== 17'h0)
        $display("FAIL on_held%0d: out=%h count=%0d want 0/0", i, out, count);
      else passed++;
    end
    on = 1'b0;
    tick(15);
    total++;
    if (count !== 4'd15 || out[16] !== 1'b0)
      $display("FAIL on_held_early: out=%h count=%0d want count=15 bit16=0", out, count);
    else passed++;
    tick();
    total++;
    if (out !== 17'h13006 || count !== 4'd0)
      $display("FAIL on_held_final: out=%h count=%0d want 13006/0", out, count);
    else passed++;
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    logic [2:0]  o;
    logic [16:0] full, part, mask;
    int hold, k;
    for (int n = 0; n < 24; n++) begin
      a = 16'($urandom); b = 16'($urandom); o = 3'($urandom_range(7));
      hold = $urandom_range(1, 5);
      k = $urandom_range(1, 15);
      full = model(a, b, o);
      mask = (17'h1 << k) - 17'h1;
      part = {1'b0, full[15:0]} & mask;
      load(a, b, o, hold);
      tick(k);
      total++;
      if (out !== part || count !== 4'(k))
        $display("FAIL rnd%0d_partial: out=%h count=%0d want %h/%0d", n, out, count, part, k);
      else passed++;
      tick(16 - k);
      total++;
      if (out !== full || count !== 4'd0)
        $display("FAIL rnd%0d_final op%0d a=%h b=%h: out=%h count=%0d want %h/0", n, o, a, b, out, count, full);
      else passed++;
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_add_partial();
    test_directed_ops();
    test_reset_mid();
    test_restart();
    test_on_held();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
